// File: rtl/unsigned_fixed_point_divider.sv
// Restoring unsigned fixed-point divider, one quotient bit per cycle.
// Optional round-half-up of the quotient when DIV_ROUND_EN is defined.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request a division (sampled while ready=1)
//   A, B            dividend / divisor, IN_WIDTH bits, FRAC_BITS fraction
//   ready           a start will be accepted this cycle
//   done            one-cycle pulse when results update
//   Quotient        A/B with FRAC_BITS fraction bits, OUT_WIDTH wide
//   Remainder       integer remainder of (A<<FRAC_BITS) mod B
//   div_by_zero     last accepted operation had B=0
module unsigned_fixed_point_divider #(
  parameter int IN_WIDTH  = 4,
  parameter int FRAC_BITS = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  output logic                 ready,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] Quotient,
  output logic [IN_WIDTH-1:0]  Remainder,
  output logic                 div_by_zero
);

  localparam int N  = IN_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int RW = IN_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state;
  logic [N-1:0]          dvd;
  logic [IN_WIDTH-1:0]   dvs;
  logic [RW-1:0]         prem;
  logic [N-1:0]          quo;
  logic [CW-1:0]         cnt;

  logic [RW-1:0]         rem_sh;
  logic [RW:0]           diff;
  logic                  qbit;
  logic [RW-1:0]         rem_nx;
  logic [N-1:0]          quo_nx;
  logic [OUT_WIDTH-1:0]  q_ext;
  logic [OUT_WIDTH-1:0]  q_fin;

  // One restoring step: the extra top bit of diff is the borrow.
  always_comb begin
    rem_sh = {prem[IN_WIDTH-1:0], dvd[N-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
    qbit   = ~diff[RW];
    rem_nx = qbit ? diff[RW-1:0] : rem_sh;
    quo_nx = {quo[N-2:0], qbit};
    q_ext  = {{(OUT_WIDTH-N){1'b0}}, quo_nx};
  end

`ifdef DIV_ROUND_EN
  logic rnd;

  // Round half up: remainder*2 >= divisor.
  always_comb begin
    rnd   = ({rem_nx, 1'b0} >= {2'b00, dvs});
    q_fin = q_ext + OUT_WIDTH'(rnd);
  end
`else
  logic unused_rem_msb;

  // Final remainder is always below the divisor, so its top bit is 0.
  assign unused_rem_msb = rem_nx[RW-1];

  always_comb begin
    q_fin = q_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      quo         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE,
        S_DONE: begin
          if (start) begin
            if (B == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              Quotient    <= '1;
              Remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              dvd   <= {A, {FRAC_BITS{1'b0}}};
              dvs   <= B;
              prem  <= '0;
              quo   <= '0;
              cnt   <= CW'(N);
              ready <= 1'b0;
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          dvd  <= {dvd[N-2:0], 1'b0};
          prem <= rem_nx;
          quo  <= quo_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= S_DONE;
            ready       <= 1'b1;
            done        <= 1'b1;
            Quotient    <= q_fin;
            Remainder   <= rem_nx[IN_WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_fixed_point_divider.sv
// Directed bench for unsigned_fixed_point_divider.
// Hand-computed Q2.2 / Q2.2 -> Q6.2 vectors, handshake and reset checks.
module tb_unsigned_fixed_point_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       ready;
  logic       done;
  logic [7:0] Quotient;
  logic [3:0] Remainder;
  logic       div_by_zero;

  int errors;
  int checks;
  int lat;
  int rlow;
  int gap;
  int pulses;

  unsigned_fixed_point_divider #(
    .IN_WIDTH (4),
    .FRAC_BITS(2),
    .OUT_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .ready      (ready),
    .done       (done),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start; return at the negedge where done is seen.
  // lat counts edges after the accepting edge; rlow counts ready=0 cycles.
  task automatic do_op(input logic [3:0] a,
                       input logic [3:0] b,
                       output int l,
                       output int r);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 0;
    r = 0;
    while (done !== 1'b1 && l < 20) begin
      if (ready === 1'b0) r++;
      @(negedge clk);
      l++;
    end
    chk("done_timeout", 32'(l < 20), 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    // 1.5 / 0.5 = 3.00
    do_op(4'b0110, 4'b0010, lat, rlow);
    chk("lat_1p5", lat, 6);
    chk("rlow_1p5", rlow, 6);
    chk("q_1p5", Quotient, 12);
    chk("r_1p5", Remainder, 0);
    chk("dbz_1p5", div_by_zero, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("q_hold", Quotient, 12);
    chk("ready_after", ready, 1);

    // 0.5 / 0.75 = 0.50 truncated, 0.75 rounded
    do_op(4'b0010, 4'b0011, lat, rlow);
`ifdef DIV_ROUND_EN
    chk("q_2d3", Quotient, 3);
`else
    chk("q_2d3", Quotient, 2);
`endif
    chk("r_2d3", Remainder, 2);

    do_op(4'd1, 4'd3, lat, rlow);
    chk("q_1d3", Quotient, 1);
    chk("r_1d3", Remainder, 1);

    do_op(4'hF, 4'h1, lat, rlow);
    chk("q_max", Quotient, 60);
    chk("r_max", Remainder, 0);

    do_op(4'h0, 4'hF, lat, rlow);
    chk("q_zero", Quotient, 0);
    chk("r_zero", Remainder, 0);

    // Divide by zero
    do_op(4'h9, 4'h0, lat, rlow);
    chk("lat_dbz", lat, 0);
    chk("q_dbz", Quotient, 8'hFF);
    chk("r_dbz", Remainder, 0);
    chk("dbz_set", div_by_zero, 1);

    // 1.25 / 0.5 = 2.50 clears the flag
    do_op(4'd5, 4'd2, lat, rlow);
    chk("dbz_clr", div_by_zero, 0);
    chk("q_5d2", Quotient, 10);
    chk("lat_5d2", lat, 6);

    // start held high with A/B churning through RUN
    A     = 4'b0110;
    B     = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    chk("run_ready", ready, 0);
    chk("run_q_hold", Quotient, 10);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      A = 4'($urandom);
      B = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("held_timeout", 32'(lat < 20), 1);
    chk("held_lat", lat, 6);
    chk("held_q", Quotient, 12);

    // Start in the DONE cycle is accepted
    A     = 4'hF;
    B     = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, 7);
    chk("b2b_q", Quotient, 60);

    // Reset three cycles into RUN
    A     = 4'b0010;
    B     = 4'b0011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_q", Quotient, 0);
    chk("abort_r", Remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    pulses = 0;
    repeat (10) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort_nodone", pulses, 0);

    do_op(4'd1, 4'd3, lat, rlow);
    chk("post_lat", lat, 6);
    chk("post_q", Quotient, 1);
    chk("post_r", Remainder, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
